vscale_fetch_unit: RTL and testbench
====================================

VSCALE_FETCH_UNIT -- requirements
Module: vscale_fetch_unit

Interface
REQ-001 Parameter XPR_LEN, default 32: address and PC width.
REQ-002 Parameter INST_WIDTH, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: prefetch buffer entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 redirect_valid  in  1  flush and refetch from redirect_pc.
REQ-009 redirect_pc  in  XPR_LEN  new fetch target; bits [1:0] ignored and treated as 0.
REQ-010 imem_req_valid  out  1  fetch request present this cycle.
REQ-011 imem_addr  out  XPR_LEN  fetch address.
REQ-012 imem_wait  in  1  memory not accepting; request held.
REQ-013 imem_rdata  in  INST_WIDTH  response data, valid the cycle after acceptance.
REQ-014 imem_badmem_e  in  1  response is an access fault; same timing as imem_rdata.
REQ-015 inst_valid  out  1  buffer head holds an instruction.
REQ-016 inst_ready  in  1  consumer takes the head.
REQ-017 inst_data  out  INST_WIDTH  head instruction.
REQ-018 inst_pc  out  XPR_LEN  head PC.
REQ-019 inst_badmem  out  1  head fetch faulted.

Function
REQ-020 A request SHALL be accepted in a cycle with imem_req_valid=1 and imem_wait=0; its response SHALL be captured unconditionally at the next rising edge.
REQ-021 At most one accepted request SHALL be in flight; back-to-back acceptance gives one fetch per cycle.
REQ-022 imem_addr SHALL equal redirect_pc (low bits zeroed) when redirect_valid=1, else fetch_pc, combinationally.
REQ-023 While imem_wait=1, imem_addr and imem_req_valid SHALL be held stable unless redirect_valid=1.
REQ-024 fetch_pc SHALL advance by 4 on acceptance, modulo 2^XPR_LEN (0xFFFFFFFC -> 0x0).
REQ-025 Issue SHALL be permitted when count+inflight < DEPTH, or count+inflight = DEPTH and a pop occurs the same cycle.
REQ-026 Pop SHALL occur when inst_valid=1 and inst_ready=1; push and pop in the same cycle leave count unchanged.
REQ-027 Response-to-inst_valid latency SHALL be one cycle with no bypass; a redirect at cycle t with no wait yields inst_valid at t+2.
REQ-028 Redirect SHALL flush all entries at the edge, discard the in-flight response, and issue to redirect_pc the same cycle; redirect wins over a simultaneous pop or push.
REQ-029 A response with imem_badmem_e=1 SHALL be buffered with inst_badmem=1; issue SHALL then stop until the next redirect.
REQ-030 inst_valid SHALL be 0 when empty; inst_* fields are don't-care then.
REQ-031 An internal state machine SHALL have states RUN (issuing), HALT (fault seen, no issue) and FLUSH-free redirect (redirect enters RUN from either state).

Reset
REQ-032 While reset_n=0: fetch_pc=RESET_PC, count=0, inflight=0, state=RUN, inst_valid=0, imem_req_valid=0.
REQ-033 First request SHALL be issued in the first cycle with reset_n=1, at RESET_PC.
REQ-034 Reset asserted mid-operation SHALL drop any in-flight response and empty the buffer.

Structure
REQ-035 DEPTH-derived pointer width and RV_NOP/INST_WIDTH constants SHALL live in the shared control-constants header.
REQ-036 Storage SHALL be one sub-module, vscale_fetch_fifo (data, pc, badmem per entry, flush input).

Verification
REQ-037 Reset release, imem_wait=0, inst_ready=1 -> addresses 0x0,0x4,0x8 on consecutive cycles; inst_pc 0x0 first valid 2 cycles after release.
REQ-038 inst_ready=0, DEPTH=4 -> exactly 4 accepted requests, then imem_req_valid=0 until a pop.
REQ-039 Redirect to 0x103 while a response is in flight -> imem_addr=0x100 same cycle, stale response never appears, next inst_pc=0x100.
REQ-040 imem_wait=1 for 3 cycles at 0x8 -> imem_addr held 0x8, no duplicate or skipped PC.
REQ-041 imem_badmem_e=1 on 0xC -> inst_badmem=1 at pc 0xC, no further requests until redirect to 0x200 resumes fetch.
REQ-042 fetch_pc 0xFFFFFFFC -> next request 0x00000000.

Source files
------------

// File: rtl/vscale_fetch_unit_pkg.sv
// Shared fetch-unit constants: instruction encoding defaults, controller states
// and the DEPTH-to-pointer-width helper used by the prefetch buffer.
package vscale_fetch_unit_pkg;

    localparam int unsigned DEFAULT_INST_WIDTH = 32;
    localparam logic [31:0] RV_NOP             = 32'h0000_0013;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/vscale_fetch_unit_fifo.sv
// Prefetch buffer: DEPTH entries of {instruction, pc, badmem} with a flush that
// empties every entry at the edge and takes priority over push and pop.
module vscale_fetch_fifo
    import vscale_fetch_unit_pkg::*;
#(
    parameter int unsigned XPR_LEN    = 32,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [INST_WIDTH-1:0]     push_data,
    input  logic [XPR_LEN-1:0]        push_pc,
    input  logic                      push_badmem,
    input  logic                      pop,
    output logic                      valid,
    output logic [INST_WIDTH-1:0]     head_data,
    output logic [XPR_LEN-1:0]        head_pc,
    output logic                      head_badmem,
    output logic [ptr_width(DEPTH):0] count
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W+1)'(DEPTH);

    logic [INST_WIDTH-1:0] data_mem [DEPTH];
    logic [XPR_LEN-1:0]    pc_mem   [DEPTH];
    logic                  bad_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy so the pointers never run past each other.
    always_comb begin
        do_pop_s  = pop & (count_r != '0);
        do_push_s = push & ((count_r != DEPTH_V) | do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents of empty slots are never observed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush && reset_n) begin
            data_mem[wr_ptr_r] <= push_data;
            pc_mem[wr_ptr_r]   <= push_pc;
            bad_mem[wr_ptr_r]  <= push_badmem;
        end
    end

    // Head view; an empty buffer presents a NOP so downstream never sees X.
    always_comb begin
        if (count_r != '0) begin
            valid       = 1'b1;
            head_data   = data_mem[rd_ptr_r];
            head_pc     = pc_mem[rd_ptr_r];
            head_badmem = bad_mem[rd_ptr_r];
        end else begin
            valid       = 1'b0;
            head_data   = INST_WIDTH'(RV_NOP);
            head_pc     = '0;
            head_badmem = 1'b0;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/vscale_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request memory interface feeding a
// DEPTH-entry prefetch buffer, with redirect flush and halt on access fault.
module vscale_fetch_unit
    import vscale_fetch_unit_pkg::*;
#(
    parameter int unsigned      XPR_LEN    = 32,
    parameter int unsigned      INST_WIDTH = 32,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [XPR_LEN-1:0] RESET_PC = {XPR_LEN{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  redirect_valid,
    input  logic [XPR_LEN-1:0]    redirect_pc,
    output logic                  imem_req_valid,
    output logic [XPR_LEN-1:0]    imem_addr,
    input  logic                  imem_wait,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  imem_badmem_e,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [XPR_LEN-1:0]    inst_pc,
    output logic                  inst_badmem
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

    fetch_state_e       state_r;
    logic [XPR_LEN-1:0] fetch_pc_r;
    logic [XPR_LEN-1:0] req_pc_r;
    logic               inflight_r;

    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_valid_s;
    logic [CNT_W:0]     occ_s;
    logic [XPR_LEN-1:0] redirect_addr_s;
    logic               fault_now_s;
    logic               pop_s;
    logic               push_s;
    logic               accept_s;

    // Issue decision: the in-flight slot counts against buffer space, and a
    // faulting response blocks the request presented alongside it.
    always_comb begin
        redirect_addr_s = {redirect_pc[XPR_LEN-1:2], 2'b00};
        inst_valid      = fifo_valid_s & reset_n;
        pop_s           = inst_valid & inst_ready;
        fault_now_s     = inflight_r & imem_badmem_e;
        occ_s           = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r};
        if (!reset_n) begin
            imem_req_valid = 1'b0;
            imem_addr      = fetch_pc_r;
        end else if (redirect_valid) begin
            imem_req_valid = 1'b1;
            imem_addr      = redirect_addr_s;
        end else if (state_r == FETCH_RUN && !fault_now_s) begin
            imem_req_valid = (occ_s < DEPTH_V) || ((occ_s == DEPTH_V) && pop_s);
            imem_addr      = fetch_pc_r;
        end else begin
            imem_req_valid = 1'b0;
            imem_addr      = fetch_pc_r;
        end
        accept_s = imem_req_valid & ~imem_wait;
        push_s   = inflight_r & ~redirect_valid;
    end

    // Fetch controller: PC sequencing, in-flight tracking and RUN/HALT state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= FETCH_RUN;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                req_pc_r   <= imem_addr;
                fetch_pc_r <= imem_addr + XPR_LEN'(4);
            end else if (redirect_valid) begin
                req_pc_r   <= req_pc_r;
                fetch_pc_r <= redirect_addr_s;
            end else begin
                req_pc_r   <= req_pc_r;
                fetch_pc_r <= fetch_pc_r;
            end
            case (state_r)
                FETCH_RUN: begin
                    if (!redirect_valid && fault_now_s) begin
                        state_r <= FETCH_HALT;
                    end else begin
                        state_r <= FETCH_RUN;
                    end
                end
                FETCH_HALT: begin
                    if (redirect_valid) begin
                        state_r <= FETCH_RUN;
                    end else begin
                        state_r <= FETCH_HALT;
                    end
                end
                default: state_r <= FETCH_RUN;
            endcase
        end
    end

    vscale_fetch_fifo #(
        .XPR_LEN   (XPR_LEN),
        .INST_WIDTH(INST_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push_s),
        .push_data  (imem_rdata),
        .push_pc    (req_pc_r),
        .push_badmem(imem_badmem_e),
        .pop        (pop_s),
        .valid      (fifo_valid_s),
        .head_data  (inst_data),
        .head_pc    (inst_pc),
        .head_badmem(inst_badmem),
        .count      (fifo_count_s)
    );

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Randomized bench for vscale_fetch_unit: a memory responder plus an
// in-order program-stream model feeding a scoreboard checked by a monitor.
module tb_vscale_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_wait = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_badmem_e = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_badmem;

    vscale_fetch_unit #(
        .XPR_LEN(32), .INST_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_addr(imem_addr),
        .imem_wait(imem_wait), .imem_rdata(imem_rdata), .imem_badmem_e(imem_badmem_e),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .inst_badmem(inst_badmem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        bad;
        int          rdy;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_pop = 1'b0;
    bit   mon_ev;

    // stimulus knobs
    bit          rst_knob = 1'b1;
    int          p_wait = 0, p_ready = 100, p_redir = 0;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0;
    int          force_wait = 0;
    bit          rand_fault = 1'b0;
    logic [31:0] fault_addr = 32'hFFFF_FFFF;

    // program-stream model
    logic [31:0] next_addr = 32'h0;
    bit          halted = 1'b0, fault_pending = 1'b0;
    bit          last_acc = 1'b0, last_bad = 1'b0;
    logic [31:0] last_addr = 32'h0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function bit is_fault(input logic [31:0] a);
        return (a == fault_addr) || (rand_fault && (a[7:0] == 8'h3C));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares the buffer head against the scoreboard and retires on pop.
    always begin
        @(posedge clk);
        #3;
        mon_ev = reset_n && (sb.size() > 0) && (sb[0].rdy <= cyc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, mon_ev});
        if (mon_ev) begin
            chk("inst_pc", inst_pc, sb[0].pc);
            chk("inst_data", inst_data, sb[0].data);
            chk("inst_badmem", {31'b0, inst_badmem}, {31'b0, sb[0].bad});
        end
        mon_pop = mon_ev && inst_ready;
        if (mon_pop) void'(sb.pop_front());
    end

    task automatic cycle_step();
        int          occ;
        bit          exp_req, acc, b;
        logic [31:0] exp_addr;
        @(posedge clk);
        #1;
        cyc++;
        reset_n        = !rst_knob;
        imem_rdata     = last_acc ? memf(last_addr) : $urandom;
        imem_badmem_e  = last_acc ? last_bad : 1'($urandom_range(0, 1));
        redirect_valid = force_redir || ($urandom_range(0, 99) < p_redir);
        if (force_redir)
            redirect_pc = force_pc;
        else if ($urandom_range(0, 3) == 0)
            redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else
            redirect_pc = 32'($urandom_range(0, 1023));
        imem_wait  = (force_wait > 0) || ($urandom_range(0, 99) < p_wait);
        inst_ready = ($urandom_range(0, 99) < p_ready);
        force_redir = 1'b0;
        if (force_wait > 0) force_wait--;

        @(negedge clk);
        occ = sb.size() + (mon_pop ? 1 : 0);
        b = 1'b0;
        if (!reset_n) begin
            exp_req = 1'b0;
            exp_addr = next_addr;
        end else if (redirect_valid) begin
            exp_req = 1'b1;
            exp_addr = {redirect_pc[31:2], 2'b00};
        end else begin
            exp_req = !halted && !fault_pending &&
                      ((occ < DEPTH) || ((occ == DEPTH) && mon_pop));
            exp_addr = next_addr;
        end
        chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_addr);
        acc = exp_req && !imem_wait;

        if (!reset_n) begin
            sb.delete();
            halted = 1'b0;
            fault_pending = 1'b0;
            next_addr = 32'h0;
            last_acc = 1'b0;
        end else begin
            if (redirect_valid) begin
                sb.delete();
                halted = 1'b0;
            end else if (fault_pending) begin
                halted = 1'b1;
            end
            if (acc) begin
                b = is_fault(exp_addr);
                sb.push_back('{exp_addr, memf(exp_addr), b, cyc + 2});
                next_addr = exp_addr + 32'd4;
            end else if (redirect_valid) begin
                next_addr = exp_addr;
            end
            fault_pending = acc && b;
            last_acc  = acc;
            last_addr = exp_addr;
            last_bad  = b;
        end
    endtask

    initial begin
        repeat (3) cycle_step();
        // release: sequential fetch from 0 until the fault at 0xC halts issue
        rst_knob = 1'b0;
        fault_addr = 32'h0000_000C;
        repeat (10) cycle_step();
        // resume at 0x200 with the consumer stalled: buffer fills, then no issue
        fault_addr = 32'hFFFF_FFFF;
        force_redir = 1'b1; force_pc = 32'h200; p_ready = 0;
        repeat (10) cycle_step();
        p_ready = 100;
        repeat (6) cycle_step();
        // redirect with a response in flight; low address bits dropped
        force_redir = 1'b1; force_pc = 32'h103;
        repeat (6) cycle_step();
        // memory stall while presenting 0x8
        force_redir = 1'b1; force_pc = 32'h0;
        repeat (2) cycle_step();
        force_wait = 3;
        repeat (8) cycle_step();
        // address wrap at the top of the space
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF4;
        repeat (8) cycle_step();
        // randomized traffic
        p_wait = 25; p_ready = 70; p_redir = 4; rand_fault = 1'b1;
        repeat (3000) cycle_step();
        // reset in the middle of traffic, then recover
        rst_knob = 1'b1;
        repeat (2) cycle_step();
        rst_knob = 1'b0; p_redir = 0; rand_fault = 1'b0;
        repeat (20) cycle_step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
